// File: rtl/maquina_estados_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | maquina_estados_ctrl_pkg : shared types/constants for control FSM  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package maquina_estados_ctrl_pkg;

  localparam int TH_W = 3;
  localparam logic [TH_W-1:0] AF_DEF = 3'd6;
  localparam logic [TH_W-1:0] AE_DEF = 3'd1;

  localparam int NUM_FIFO   = 5;
  localparam int NUM_LANES  = 4;
  localparam int FIFO_IN    = 0;
  localparam int FIFO_LANE0 = 1;

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } state_e;

  function automatic logic umbral_valid(input logic [TH_W-1:0] af,
                                        input logic [TH_W-1:0] ae);
    return (af != '0) && (ae < af);
  endfunction

endpackage
`default_nettype wire

// File: rtl/maquina_estados_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | maquina_estados_ctrl_if : config/flag/status bundle of control FSM |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface maquina_estados_ctrl_if;
  import maquina_estados_ctrl_pkg::*;

  logic                init;
  logic [TH_W-1:0]     umbral_af_in;
  logic [TH_W-1:0]     umbral_ae_in;
  logic [NUM_FIFO-1:0] fifo_empty;
  logic [NUM_FIFO-1:0] fifo_error;
  logic [3:0]          state;
  logic [TH_W-1:0]     umbral_af;
  logic [TH_W-1:0]     umbral_ae;
  logic                idle;
  logic                error_out;
  logic                cfg_invalid;

  modport master (
    output init, umbral_af_in, umbral_ae_in, fifo_empty, fifo_error,
    input  state, umbral_af, umbral_ae, idle, error_out, cfg_invalid
  );

  modport slave (
    input  init, umbral_af_in, umbral_ae_in, fifo_empty, fifo_error,
    output state, umbral_af, umbral_ae, idle, error_out, cfg_invalid
  );

endinterface
`default_nettype wire

// File: rtl/maquina_estados_ctrl_umbral_regs.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | maquina_estados_ctrl_umbral_regs : threshold regs + validity check |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module maquina_estados_ctrl_umbral_regs
  import maquina_estados_ctrl_pkg::*;
(
  input  wire logic            clk,
  input  wire logic            reset_L,
  input  wire logic            load_i,
  input  wire logic            in_init_d_i,
  input  wire logic [TH_W-1:0] af_in_i,
  input  wire logic [TH_W-1:0] ae_in_i,
  output logic      [TH_W-1:0] umbral_af_o,
  output logic      [TH_W-1:0] umbral_ae_o,
  output logic                 cfg_ok_o,
  output logic                 cfg_invalid_o
);

  logic [TH_W-1:0] af_q;
  logic [TH_W-1:0] ae_q;
  logic            ok_q;
  logic            ok_d;
  logic            inv_q;
  logic            pair_valid;

  // ok tracks the last pair offered, while af/ae only ever hold valid pairs
  always_comb begin
    pair_valid = umbral_valid(af_in_i, ae_in_i);
    ok_d       = load_i ? pair_valid : ok_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      af_q  <= AF_DEF;
      ae_q  <= AE_DEF;
      ok_q  <= 1'b1;
      inv_q <= 1'b0;
    end else begin
      if (load_i && pair_valid) begin
        af_q <= af_in_i;
        ae_q <= ae_in_i;
      end
      ok_q  <= ok_d;
      inv_q <= in_init_d_i && !ok_d;
    end
  end

  assign umbral_af_o   = af_q;
  assign umbral_ae_o   = ae_q;
  assign cfg_ok_o      = ok_q;
  assign cfg_invalid_o = inv_q;

endmodule
`default_nettype wire

// File: rtl/maquina_estados_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | maquina_estados_ctrl : one-hot control FSM for FIFO/arbiter path   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module maquina_estados_ctrl
  import maquina_estados_ctrl_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             reset_L,
  maquina_estados_ctrl_if.slave bus
);

  state_e state_q;
  state_e state_d;
  logic   idle_q;
  logic   error_q;
  logic   cfg_ok;
  logic   load;
  logic   any_err;
  logic   any_busy;
  logic   running;

  always_comb begin
    load     = (state_q == ST_INIT) && bus.init;
    any_err  = |bus.fifo_error;
    any_busy = !bus.fifo_empty[FIFO_IN] || !(&bus.fifo_empty[FIFO_LANE0 +: NUM_LANES]);
    running  = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
  end

  always_comb begin
    state_d = ST_RESET;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   state_d = (!bus.init && cfg_ok) ? ST_IDLE : ST_INIT;
      ST_IDLE: begin
        if (any_err)       state_d = ST_RESET;
        else if (bus.init) state_d = ST_INIT;
        else if (any_busy) state_d = ST_ACTIVE;
        else               state_d = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (any_err)       state_d = ST_RESET;
        else if (bus.init) state_d = ST_INIT;
        else if (any_busy) state_d = ST_ACTIVE;
        else               state_d = ST_IDLE;
      end
      default:   state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q <= ST_RESET;
      idle_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idle_q  <= (state_d == ST_IDLE);
      if (running && any_err) begin
        error_q <= 1'b1;
      end
    end
  end

  maquina_estados_ctrl_umbral_regs u_umbral_regs (
    .clk           (clk),
    .reset_L       (reset_L),
    .load_i        (load),
    .in_init_d_i   (state_d == ST_INIT),
    .af_in_i       (bus.umbral_af_in),
    .ae_in_i       (bus.umbral_ae_in),
    .umbral_af_o   (bus.umbral_af),
    .umbral_ae_o   (bus.umbral_ae),
    .cfg_ok_o      (cfg_ok),
    .cfg_invalid_o (bus.cfg_invalid)
  );

  assign bus.state     = state_q;
  assign bus.idle      = idle_q;
  assign bus.error_out = error_q;

endmodule
`default_nettype wire

// File: tb/tb_maquina_estados_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_maquina_estados_ctrl : randomized + directed bench, ref model   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_maquina_estados_ctrl;
  import maquina_estados_ctrl_pkg::*;

  localparam int M_RESET  = 0;
  localparam int M_INIT   = 1;
  localparam int M_IDLE   = 2;
  localparam int M_ACTIVE = 3;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  int   checks = 0;
  int   errors = 0;

  maquina_estados_ctrl_if bus ();

  maquina_estados_ctrl dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: state as an index 0..3, one-hot is 1 << index
  int       m_st  = M_RESET;
  bit [2:0] m_af  = 3'd6;
  bit [2:0] m_ae  = 3'd1;
  bit       m_ok  = 1'b1;
  bit       m_err = 1'b0;
  bit       m_inv = 1'b0;

  task automatic drive(input bit rl, input bit in, input bit [2:0] af,
                       input bit [2:0] ae, input bit [4:0] fe, input bit [4:0] fer);
    reset_L          = rl;
    bus.init         = in;
    bus.umbral_af_in = af;
    bus.umbral_ae_in = ae;
    bus.fifo_empty   = fe;
    bus.fifo_error   = fer;
  endtask

  task automatic clock();
    int  nxt;
    bit  pair_ok;
    @(posedge clk);
    if (!reset_L) begin
      m_st = M_RESET; m_af = 3'd6; m_ae = 3'd1; m_ok = 1'b1; m_err = 1'b0; m_inv = 1'b0;
    end else begin
      pair_ok = (bus.umbral_af_in != 0) && (bus.umbral_ae_in < bus.umbral_af_in);
      nxt = m_st;
      if (m_st == M_RESET) begin
        nxt = M_INIT;
      end else if (m_st == M_INIT) begin
        if (bus.init) begin
          if (pair_ok) begin m_af = bus.umbral_af_in; m_ae = bus.umbral_ae_in; end
          m_ok = pair_ok;
          nxt  = M_INIT;
        end else begin
          nxt = m_ok ? M_IDLE : M_INIT;
        end
      end else begin
        if (bus.fifo_error != 0) begin nxt = M_RESET; m_err = 1'b1; end
        else if (bus.init) nxt = M_INIT;
        else nxt = (bus.fifo_empty == 5'b11111) ? M_IDLE : M_ACTIVE;
      end
      m_st  = nxt;
      m_inv = (nxt == M_INIT) && !m_ok;
    end
    #1;
  endtask

  function automatic logic [12:0] expv();
    return {4'(1 << m_st), m_af, m_ae, (m_st == M_IDLE), m_err, m_inv};
  endfunction

  function automatic logic [12:0] obsv();
    return {bus.state, bus.umbral_af, bus.umbral_ae, bus.idle, bus.error_out, bus.cfg_invalid};
  endfunction

  task automatic test_reset();
    drive(0, 0, 3'd6, 3'd1, 5'b11111, 5'b0);
    repeat (3) clock();
    checks++;
    if (bus.state !== 4'b0001 || bus.umbral_af !== 3'd6 || bus.umbral_ae !== 3'd1 ||
        bus.idle !== 1'b0 || bus.error_out !== 1'b0 || bus.cfg_invalid !== 1'b0) begin
      errors++; $display("FAIL reset_state got %b required %b", obsv(), 13'b0001_110_001_000);
    end
    drive(1, 0, 3'd6, 3'd1, 5'b11111, 5'b0);
    clock();
    checks++;
    if (bus.state !== 4'b0010) begin
      errors++; $display("FAIL reset_to_init got %b required 0010", bus.state);
    end
    clock();
    checks++;
    if (bus.state !== 4'b0100 || bus.idle !== 1'b1 || obsv() !== expv()) begin
      errors++; $display("FAIL reset_to_idle got %b required %b", obsv(), expv());
    end
  endtask

  task automatic test_programming();
    drive(1, 1, 3'd5, 3'd2, 5'b11111, 5'b0);
    repeat (2) clock();
    drive(1, 0, 3'd5, 3'd2, 5'b11111, 5'b0);
    clock();
    checks++;
    if (bus.state !== 4'b0100 || bus.umbral_af !== 3'd5 || bus.umbral_ae !== 3'd2 ||
        bus.cfg_invalid !== 1'b0) begin
      errors++; $display("FAIL program got %b required state 0100 af 5 ae 2 inv 0", obsv());
    end
  endtask

  task automatic test_invalid_cfg();
    drive(1, 1, 3'd2, 3'd3, 5'b11111, 5'b0);
    repeat (2) clock();
    drive(1, 0, 3'd2, 3'd3, 5'b11111, 5'b0);
    repeat (2) clock();
    checks++;
    if (bus.state !== 4'b0010 || bus.cfg_invalid !== 1'b1 ||
        bus.umbral_af !== 3'd5 || bus.umbral_ae !== 3'd2) begin
      errors++; $display("FAIL invalid_cfg got %b required state 0010 af 5 ae 2 inv 1", obsv());
    end
    drive(1, 1, 3'd0, 3'd0, 5'b11111, 5'b0);
    clock();
    checks++;
    if (bus.cfg_invalid !== 1'b1 || bus.umbral_af !== 3'd5) begin
      errors++; $display("FAIL zero_af got %b required inv 1 af 5", obsv());
    end
    drive(1, 1, 3'd7, 3'd6, 5'b11111, 5'b0);
    clock();
    drive(1, 0, 3'd7, 3'd6, 5'b11111, 5'b0);
    clock();
    checks++;
    if (bus.state !== 4'b0100 || bus.cfg_invalid !== 1'b0 || obsv() !== expv()) begin
      errors++; $display("FAIL cfg_recover got %b required %b", obsv(), expv());
    end
  endtask

  task automatic test_traffic();
    drive(1, 0, 3'd0, 3'd0, 5'b11110, 5'b0);
    clock();
    checks++;
    if (bus.state !== 4'b1000 || bus.idle !== 1'b0) begin
      errors++; $display("FAIL traffic_active got %b required state 1000 idle 0", obsv());
    end
    drive(1, 0, 3'd0, 3'd0, 5'b01111, 5'b0);
    clock();
    checks++;
    if (bus.state !== 4'b1000) begin
      errors++; $display("FAIL traffic_lane3 got %b required 1000", bus.state);
    end
    drive(1, 0, 3'd0, 3'd0, 5'b11111, 5'b0);
    clock();
    checks++;
    if (bus.state !== 4'b0100 || bus.idle !== 1'b1 || bus.umbral_af !== 3'd7) begin
      errors++; $display("FAIL traffic_idle got %b required state 0100 idle 1 af 7", obsv());
    end
  endtask

  task automatic test_error_recovery();
    drive(1, 0, 3'd0, 3'd0, 5'b11101, 5'b0);
    clock();
    drive(1, 0, 3'd0, 3'd0, 5'b11101, 5'b00100);
    clock();
    checks++;
    if (bus.state !== 4'b0001 || bus.error_out !== 1'b1) begin
      errors++; $display("FAIL err_reset got %b required state 0001 err 1", obsv());
    end
    drive(1, 0, 3'd0, 3'd0, 5'b11111, 5'b00001);
    clock();
    checks++;
    if (bus.state !== 4'b0010 || bus.error_out !== 1'b1) begin
      errors++; $display("FAIL err_init got %b required state 0010 err 1", obsv());
    end
    drive(1, 1, 3'd4, 3'd1, 5'b11111, 5'b10000);
    clock();
    checks++;
    if (bus.state !== 4'b0010 || bus.umbral_af !== 3'd4 || obsv() !== expv()) begin
      errors++; $display("FAIL err_ignored_init got %b required %b", obsv(), expv());
    end
    drive(1, 0, 3'd4, 3'd1, 5'b11111, 5'b0);
    clock();
    checks++;
    if (bus.state !== 4'b0100 || bus.error_out !== 1'b1) begin
      errors++; $display("FAIL err_sticky got %b required state 0100 err 1", obsv());
    end
    drive(0, 0, 3'd4, 3'd1, 5'b11111, 5'b0);
    clock();
    checks++;
    if (bus.error_out !== 1'b0 || bus.umbral_af !== 3'd6 || bus.umbral_ae !== 3'd1) begin
      errors++; $display("FAIL err_clear got %b required err 0 af 6 ae 1", obsv());
    end
  endtask

  task automatic test_simultaneity();
    drive(1, 0, 3'd0, 3'd0, 5'b11111, 5'b0);
    repeat (2) clock();
    drive(1, 1, 3'd5, 3'd2, 5'b11111, 5'b01000);
    clock();
    checks++;
    if (bus.state !== 4'b0001 || bus.error_out !== 1'b1) begin
      errors++; $display("FAIL err_over_init got %b required state 0001 err 1", obsv());
    end
    drive(1, 0, 3'd0, 3'd0, 5'b11111, 5'b0);
    repeat (2) clock();
    drive(0, 1, 3'd5, 3'd2, 5'b11111, 5'b00010);
    clock();
    checks++;
    if (bus.state !== 4'b0001 || bus.error_out !== 1'b0 || obsv() !== expv()) begin
      errors++; $display("FAIL reset_over_err got %b required %b", obsv(), expv());
    end
  endtask

  task automatic test_random();
    bit       rl;
    bit       in;
    bit [4:0] fe;
    bit [4:0] fer;
    for (int i = 0; i < 400; i++) begin
      rl  = ($urandom_range(0, 39) != 0);
      in  = ($urandom_range(0, 5) == 0);
      fe  = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'b11111;
      fer = ($urandom_range(0, 15) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'b0;
      drive(rl, in, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), fe, fer);
      clock();
      checks++;
      if (obsv() !== expv()) begin
        errors++; $display("FAIL random cycle %0d got %b required %b", i, obsv(), expv());
      end
    end
  endtask

  initial begin
    drive(0, 0, 3'd6, 3'd1, 5'b11111, 5'b0);
    test_reset();
    test_programming();
    test_invalid_cfg();
    test_traffic();
    test_error_recovery();
    test_simultaneity();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
